// File: rtl/ldd_pulse_gen.sv
// ldd_pulse_gen: per-channel laser write-disable timing generator.
// Each enabled channel runs delay -> pulse -> holdoff from one trigger.
module ldd_pulse_gen #(
    parameter int TOP0_0 = 3,
    parameter int CW     = 16,
    parameter int MW     = 16
) (
    input  logic                 clk200,
    input  logic                 rst_n,
    input  logic                 trig,
    input  logic [TOP0_0-1:0]    ch_en,
    input  logic                 kill,
    input  logic [TOP0_0*CW-1:0] dly_cfg,
    input  logic [TOP0_0*CW-1:0] wid_cfg,
    input  logic [TOP0_0*CW-1:0] hld_cfg,
    output logic [TOP0_0-1:0]    com_wdis,
    output logic [TOP0_0-1:0]    busy,
    output logic [MW-1:0]        miss_cnt,
    input  logic                 miss_clr
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        PULSE,
        HOLD
    } state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [TOP0_0-1:0] active;
    logic [TOP0_0-1:0] wdis_q;
    logic [TOP0_0-1:0] busy_q;
    logic              miss;

    for (genvar i = 0; i < TOP0_0; i++) begin : g_ch
        state_t        st;
        state_t        st_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic [CW-1:0] wid_s;
        logic [CW-1:0] wid_nxt;
        logic [CW-1:0] hld_s;
        logic [CW-1:0] hld_nxt;
        logic [CW-1:0] dly_c;
        logic [CW-1:0] wid_c;
        logic [CW-1:0] hld_c;
        logic          wdis_r;
        logic          busy_r;

        assign dly_c     = dly_cfg[i*CW +: CW];
        assign wid_c     = wid_cfg[i*CW +: CW];
        assign hld_c     = hld_cfg[i*CW +: CW];
        assign active[i] = (st != IDLE);
        assign wdis_q[i] = wdis_r;
        assign busy_q[i] = busy_r;

        // State, remaining-count and shadow config registers
        always_ff @(posedge clk200) begin
            if (!rst_n) begin
                st     <= IDLE;
                cnt    <= '0;
                wid_s  <= '0;
                hld_s  <= '0;
                wdis_r <= 1'b1;
                busy_r <= 1'b0;
            end else begin
                st     <= st_nxt;
                cnt    <= cnt_nxt;
                wid_s  <= wid_nxt;
                hld_s  <= hld_nxt;
                wdis_r <= (st_nxt != PULSE);
                busy_r <= (st_nxt != IDLE);
            end
        end

        // Next state: cnt holds cycles left in the current state
        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            wid_nxt = wid_s;
            hld_nxt = hld_s;
            if (kill) begin
                st_nxt  = IDLE;
                cnt_nxt = '0;
            end else begin
                unique case (st)
                    IDLE: begin
                        if (trig && ch_en[i]) begin
                            wid_nxt = wid_c;
                            hld_nxt = hld_c;
                            if (dly_c != '0) begin
                                st_nxt  = DELAY;
                                cnt_nxt = dly_c;
                            end else if (wid_c != '0) begin
                                st_nxt  = PULSE;
                                cnt_nxt = wid_c;
                            end else if (hld_c != '0) begin
                                st_nxt  = HOLD;
                                cnt_nxt = hld_c;
                            end
                        end
                    end
                    DELAY: begin
                        if (cnt == ONE) begin
                            if (wid_s != '0) begin
                                st_nxt  = PULSE;
                                cnt_nxt = wid_s;
                            end else if (hld_s != '0) begin
                                st_nxt  = HOLD;
                                cnt_nxt = hld_s;
                            end else begin
                                st_nxt  = IDLE;
                                cnt_nxt = '0;
                            end
                        end else begin
                            cnt_nxt = cnt - ONE;
                        end
                    end
                    PULSE: begin
                        if (cnt == ONE) begin
                            if (hld_s != '0) begin
                                st_nxt  = HOLD;
                                cnt_nxt = hld_s;
                            end else begin
                                st_nxt  = IDLE;
                                cnt_nxt = '0;
                            end
                        end else begin
                            cnt_nxt = cnt - ONE;
                        end
                    end
                    HOLD: begin
                        if (cnt == ONE) begin
                            st_nxt  = IDLE;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt - ONE;
                        end
                    end
                    default: begin
                        st_nxt  = IDLE;
                        cnt_nxt = '0;
                    end
                endcase
            end
        end
    end

    assign com_wdis = wdis_q;
    assign busy     = busy_q;

    // A trigger is missed once per cycle if any enabled channel is running
    assign miss = trig && !kill && |(ch_en & active);

    // Saturating missed-trigger counter; clear beats increment
    always_ff @(posedge clk200) begin
        if (!rst_n) begin
            miss_cnt <= '0;
        end else if (miss_clr) begin
            miss_cnt <= '0;
        end else if (miss && !(&miss_cnt)) begin
            miss_cnt <= miss_cnt + MW'(1);
        end
    end

endmodule

// File: doc/ldd_pulse_gen.md
Name: ldd_pulse_gen

Overview:
- Per-channel laser write-disable timing generator.
- Produces the `com_wdis` vector consumed by the LDD output stage. That stage muxes it against `cap_wdis`, registers it and drives the differential pins.
- On each accepted trigger, every enabled channel runs its own delay, pulse-width and holdoff sequence from the 200 MHz domain.
- Holdoff enforces a minimum re-fire interval per channel (duty/eye-safety guard).

Parameters:
- `TOP0_0`, 3, number of LDD channels; matches the output stage width.
- `CW`, 16, width of each delay/width/holdoff count field.
- `MW`, 16, width of the missed-trigger counter.

Ports:
- `clk200`  in  1  200 MHz clock; the block's only clock.
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk200`.
- `trig`  in  1  one-cycle trigger pulse, synchronous to `clk200`.
- `ch_en`  in  `TOP0_0`  per-channel enable; sampled when a trigger is accepted.
- `kill`  in  1  global abort; level-sensitive.
- `dly_cfg`  in  `TOP0_0*CW`  per-channel delay in cycles; channel i uses bits `[i*CW +: CW]`.
- `wid_cfg`  in  `TOP0_0*CW`  per-channel pulse width in cycles.
- `hld_cfg`  in  `TOP0_0*CW`  per-channel holdoff in cycles.
- `com_wdis`  out  `TOP0_0`  registered write-disable; 1 = laser disabled, 0 = emission window.
- `busy`  out  `TOP0_0`  registered; 1 while the channel is not in IDLE.
- `miss_cnt`  out  `MW`  saturating count of triggers rejected on busy enabled channels.
- `miss_clr`  in  1  synchronous clear of `miss_cnt`.

Behaviour:
- Reset: while `rst_n` = 0 at a clock edge:
  - `com_wdis` = all ones, `busy` = 0, `miss_cnt` = 0.
  - All channel FSMs go to IDLE and all counters clear.
  - Reset mid-pulse ends the pulse: `com_wdis` is 1 in the cycle after the reset edge.
- Per-channel FSM states: IDLE, DELAY, PULSE, HOLD.
- IDLE:
  - If `trig` = 1 and `ch_en[i]` = 1, latch `dly`/`wid`/`hld[i]` into shadow registers.
  - Go to DELAY if dly > 0. Else PULSE if wid > 0. Else HOLD if hld > 0. Else stay in IDLE.
  - Config changes after acceptance have no effect on the running sequence.
- DELAY: counts dly cycles, then goes to PULSE if wid > 0, else HOLD if hld > 0, else IDLE.
- PULSE: `com_wdis[i]` = 0 for exactly wid cycles, then HOLD if hld > 0, else IDLE.
- HOLD: counts hld cycles with `com_wdis[i]` = 1, then IDLE.
- Timing for a trigger accepted in cycle T, stated as values of the registered outputs:
  - `com_wdis[i]` = 0 in cycles T+1+dly through T+dly+wid.
  - `busy[i]` = 1 from T+1 through T+dly+wid+hld.
  - The next trigger is accepted in cycle T+dly+wid+hld+1 at the earliest.
- Zero widths collapse as above. dly = wid = hld = 0 produces no activity and no busy.
- Missed trigger: `trig` = 1 while any channel with `ch_en` = 1 is not in IDLE.
  - That channel ignores the trigger and continues its sequence.
  - `miss_cnt` increments once per such trigger cycle, regardless of how many channels are busy, and saturates at all ones.
  - Idle enabled channels still start on that same trigger.
- `miss_clr` priority:
  - `miss_clr` and a miss in the same cycle → `miss_cnt` = 0; clear wins.
  - `miss_clr` has no effect on the FSMs.
- `kill`:
  - While `kill` = 1, all FSMs are forced to IDLE and `com_wdis` = all ones from the next cycle on.
  - Triggers are ignored while `kill` = 1 and do not count as misses.
  - When `kill` and `trig` are both 1 in the same cycle, kill wins.
- Disabled channels (`ch_en[i]` = 0 at trigger) stay in IDLE with `com_wdis[i]` = 1.
- Clearing `ch_en[i]` mid-sequence does not abort that channel.
- Counters are `CW` bits, unsigned, with no wrap. A maximum value of 2^CW−1 is honoured exactly.

Test Plan:
1. Reset then single trigger with `ch_en` = 3'b001, dly = 4, wid = 3, hld = 5 on channel 0, trig at cycle 10:
   - `com_wdis[0]` low in cycles 15–17, otherwise high.
   - `busy[0]` high in cycles 11–22.
   - `com_wdis[2:1]` stay high.
2. dly = 0, wid = 1, hld = 0 on channel 1, trig at cycle 20: `com_wdis[1]` is low only in cycle 21, and a trigger at cycle 22 is accepted.
3. Channel 0 with dly = 2, wid = 10, hld = 10, trig at cycle 0, triggers at cycles 5 and 12:
   - Both later triggers are rejected and `miss_cnt` = 2.
   - The pulse is unaffected.
   - `miss_clr` together with a miss in one cycle → `miss_cnt` = 0.
4. `kill` asserted at cycle 6 of a running wid = 20 pulse:
   - `com_wdis` = 3'b111 and `busy` = 0 from cycle 7.
   - A trig at cycle 8 with `kill` still high is ignored and `miss_cnt` is unchanged.
5. `rst_n` driven low for 1 cycle mid-PULSE, with all channels enabled and distinct configs: outputs return to reset values the next cycle, and the next trigger produces full sequences.
6. wid = 0, dly = 3, hld = 2, trig at cycle 0: `com_wdis` never goes low, `busy` is high in cycles 1–5, and a trigger at cycle 6 is accepted.
